// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas
//   Control unit for a progressive-sequence memory game (Genius style).
//   Round r asks the player to repeat memory positions 0..r; the game grows
//   one position per round up to N_RODADAS rounds. The unit owns the address
//   counter, the round counter and a per-move timeout timer, so the datapath
//   only supplies the memory, the comparator and the jogada register.
//
// Ports
//   clock         in   rising-edge system clock
//   reset         in   asynchronous active-low reset (0 = reset)
//   iniciar       in   start/restart request, level sampled on clock
//   jogada        in   one-cycle pulse: player pressed a button
//   igual         in   comparator result: registered jogada == memory[endereco]
//   modo_timeout  in   1 = per-move timeout enabled, 0 = wait forever
//   zeraR         out  clear jogada register
//   registraR     out  load jogada register
//   endereco      out  memory address of the expected position
//   rodada        out  current round index (0-based)
//   pronto        out  game finished (won, lost or timed out)
//   ganhou        out  finished by winning
//   perdeu        out  finished by wrong move
//   timeout       out  finished by timeout
//   db_estado     out  debug: current state code (0xF for an unused code)
//
// Input contract: jogada is a single-cycle pulse from the edge detector and
// is only acted upon in espera; a pulse in any other state is dropped.
// iniciar is a level and is only looked at in inicial and the terminal states.
module unidade_controle_rodadas #(
  parameter int N_RODADAS      = 16,
  parameter int W_END          = 4,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int W_TIMER        = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             jogada,
  input  logic             igual,
  input  logic             modo_timeout,
  output logic             zeraR,
  output logic             registraR,
  output logic [W_END-1:0] endereco,
  output logic [W_END-1:0] rodada,
  output logic             pronto,
  output logic             ganhou,
  output logic             perdeu,
  output logic             timeout,
  output logic [3:0]       db_estado
);

  localparam logic [W_END-1:0]   ULTIMA_RODADA = W_END'(N_RODADAS - 1);
  localparam logic [W_TIMER-1:0] TIMER_LIMITE  = W_TIMER'(TIMEOUT_CICLOS - 1);

  // Encodings double as the debug codes seen on db_estado.
  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    INICIO_RODADA = 4'h2,
    ESPERA        = 4'h3,
    REGISTRA      = 4'h4,
    COMPARACAO    = 4'h5,
    PROX_JOGADA   = 4'h6,
    PROX_RODADA   = 4'h7,
    FIM_GANHOU    = 4'hA,
    FIM_TIMEOUT   = 4'hC,
    FIM_PERDEU    = 4'hE
  } estado_t;

  estado_t            estado;
  estado_t            proximo;
  logic [W_TIMER-1:0] timer;

  // Next-state logic. An unused code falls through to inicial.
  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:       proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:    proximo = INICIO_RODADA;
      INICIO_RODADA: proximo = ESPERA;
      ESPERA: begin
        // Timeout wins over a jogada arriving in the same cycle.
        if (modo_timeout && (timer == TIMER_LIMITE)) proximo = FIM_TIMEOUT;
        else if (jogada)                            proximo = REGISTRA;
        else                                        proximo = ESPERA;
      end
      REGISTRA:      proximo = COMPARACAO;
      COMPARACAO: begin
        if (!igual)                       proximo = FIM_PERDEU;
        else if (endereco != rodada)      proximo = PROX_JOGADA;
        else if (rodada == ULTIMA_RODADA) proximo = FIM_GANHOU;
        else                              proximo = PROX_RODADA;
      end
      PROX_JOGADA:   proximo = ESPERA;
      PROX_RODADA:   proximo = INICIO_RODADA;
      FIM_GANHOU,
      FIM_TIMEOUT,
      FIM_PERDEU:    proximo = iniciar ? PREPARACAO : estado;
      default:       proximo = INICIAL;
    endcase
  end

  // State, counters and Moore outputs. The outputs are registered from the
  // next state so they line up with the state register, glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      endereco  <= '0;
      rodada    <= '0;
      timer     <= '0;
      zeraR     <= 1'b1;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      ganhou    <= 1'b0;
      perdeu    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      estado <= proximo;

      case (estado)
        PREPARACAO: begin
          rodada   <= '0;
          endereco <= '0;
          timer    <= '0;
        end
        INICIO_RODADA: begin
          endereco <= '0;
          timer    <= '0;
        end
        // Free-running while waiting; a wrap with the timeout disabled is harmless.
        ESPERA:      timer <= timer + 1'b1;
        PROX_JOGADA: begin
          endereco <= endereco + 1'b1;
          timer    <= '0;
        end
        PROX_RODADA: rodada <= rodada + 1'b1;
        default: ;
      endcase

      zeraR     <= (proximo == INICIAL) || (proximo == PREPARACAO);
      registraR <= (proximo == REGISTRA);
      pronto    <= (proximo == FIM_GANHOU) || (proximo == FIM_PERDEU) ||
                   (proximo == FIM_TIMEOUT);
      ganhou    <= (proximo == FIM_GANHOU);
      perdeu    <= (proximo == FIM_PERDEU);
      timeout   <= (proximo == FIM_TIMEOUT);
    end
  end

  // Debug code straight from the state register; an unused code shows 0xF
  // for the single cycle before the FSM recovers into inicial.
  always_comb begin
    case (estado)
      INICIAL, PREPARACAO, INICIO_RODADA, ESPERA, REGISTRA, COMPARACAO,
      PROX_JOGADA, PROX_RODADA, FIM_GANHOU, FIM_TIMEOUT, FIM_PERDEU:
        db_estado = estado;
      default:
        db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for unidade_controle_rodadas with N_RODADAS=4, W_END=2,
// TIMEOUT_CICLOS=8, W_TIMER=3. A game-level reference model tracks the
// phase, round, position and cycles spent waiting; a compare process checks
// every DUT output against it on each falling edge, and directed scenarios
// add literal expectations.
module tb_unidade_controle_rodadas;

  localparam int NR = 4;
  localparam int WE = 2;
  localparam int TC = 8;
  localparam int WT = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          iniciar = 1'b0;
  logic          jogada = 1'b0;
  logic          igual = 1'b0;
  logic          modo_timeout = 1'b0;
  logic          zeraR, registraR, pronto, ganhou, perdeu, timeout;
  logic [WE-1:0] endereco, rodada;
  logic [3:0]    db_estado;

  unidade_controle_rodadas #(
    .N_RODADAS(NR), .W_END(WE), .TIMEOUT_CICLOS(TC), .W_TIMER(WT)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .modo_timeout(modo_timeout), .zeraR(zeraR),
    .registraR(registraR), .endereco(endereco), .rodada(rodada),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .db_estado(db_estado)
  );

  int errors = 0;
  int checks = 0;
  bit run_check = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase uses the documented debug codes; m_wait counts cycles spent in the
  // waiting phase since it was (re)entered, the timer being that count
  // modulo 2**WT.
  int m_state = 0;
  int m_end   = 0;
  int m_rod   = 0;
  int m_wait  = 0;

  task automatic model_step();
    case (m_state)
      0: if (iniciar) m_state = 1;
      1: begin m_rod = 0; m_end = 0; m_wait = 0; m_state = 2; end
      2: begin m_end = 0; m_wait = 0; m_state = 3; end
      3: begin
        if (modo_timeout && ((m_wait % (1 << WT)) == TC - 1)) m_state = 12;
        else if (jogada) m_state = 4;
        m_wait++;
      end
      4: m_state = 5;
      5: begin
        if (!igual)             m_state = 14;
        else if (m_end < m_rod) m_state = 6;
        else if (m_rod == NR-1) m_state = 10;
        else                    m_state = 7;
      end
      6: begin m_end++; m_wait = 0; m_state = 3; end
      7: begin m_rod++; m_state = 2; end
      default: if (iniciar) m_state = 1;
    endcase
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_end = 0; m_rod = 0; m_wait = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    if (reset && run_check) begin
      cmp("sb_db_estado", db_estado, m_state);
      cmp("sb_zeraR", zeraR, int'(m_state == 0 || m_state == 1));
      cmp("sb_registraR", registraR, int'(m_state == 4));
      cmp("sb_pronto", pronto, int'(m_state == 10 || m_state == 12 || m_state == 14));
      cmp("sb_ganhou", ganhou, int'(m_state == 10));
      cmp("sb_perdeu", perdeu, int'(m_state == 14));
      cmp("sb_timeout", timeout, int'(m_state == 12));
      cmp("sb_endereco", endereco, m_end);
      cmp("sb_rodada", rodada, m_rod);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ini, input logic jog);
    iniciar = ini;
    jogada  = jog;
    @(negedge clock);
    iniciar = 1'b0;
    jogada  = 1'b0;
  endtask

  task automatic wait_model(input int code, input int budget);
    int n = 0;
    while (m_state != code && n < budget) begin
      drive(1'b0, 1'b0);
      n++;
    end
    if (m_state != code) begin
      checks++;
      errors++;
      $display("FAIL wait_state: state %0d never reached, model at %0d", code, m_state);
    end
  endtask

  task automatic play_move(input logic ig, input int delay);
    int n = 0;
    wait_model(3, 40);
    repeat (delay) drive(1'b0, 1'b0);
    igual = ig;
    drive(1'b0, 1'b1);
    while ((m_state == 4 || m_state == 5) && n < 10) begin
      drive(1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, "_db"}, db_estado, 0);
    cmp({tag, "_zeraR"}, zeraR, 1);
    cmp({tag, "_registraR"}, registraR, 0);
    cmp({tag, "_pronto"}, pronto, 0);
    cmp({tag, "_ganhou"}, ganhou, 0);
    cmp({tag, "_perdeu"}, perdeu, 0);
    cmp({tag, "_timeout"}, timeout, 0);
    cmp({tag, "_endereco"}, endereco, 0);
    cmp({tag, "_rodada"}, rodada, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("rst");
    reset = 1'b1;
    run_check = 1'b1;

    // Start-up sequence 0,1,2,3.
    drive(1'b0, 1'b0);
    cmp("idle_db", db_estado, 0);
    drive(1'b1, 1'b0);
    cmp("start_db1", db_estado, 1);
    cmp("start_zeraR", zeraR, 1);
    drive(1'b0, 1'b0);
    cmp("start_db2", db_estado, 2);
    cmp("start_zeraR2", zeraR, 0);
    drive(1'b0, 1'b0);
    cmp("start_db3", db_estado, 3);
    cmp("start_end", endereco, 0);
    cmp("start_rod", rodada, 0);

    // Ten correct moves win the game.
    for (int r = 0; r < NR; r++)
      for (int m = 0; m <= r; m++)
        play_move(1'b1, (r + m) % 5);
    cmp("win_ganhou", ganhou, 1);
    cmp("win_pronto", pronto, 1);
    cmp("win_db", db_estado, 4'hA);
    cmp("win_rod", rodada, 3);
    cmp("win_end", endereco, 3);
    cmp("win_perdeu", perdeu, 0);

    // Restart from ganhou.
    drive(1'b1, 1'b0);
    cmp("restart_db", db_estado, 1);
    drive(1'b0, 1'b0);
    cmp("restart_db2", db_estado, 2);
    cmp("restart_rod", rodada, 0);
    cmp("restart_end", endereco, 0);

    // Wrong second move in round 2.
    play_move(1'b1, 1);
    play_move(1'b1, 0);
    play_move(1'b1, 0);
    play_move(1'b1, 2);
    play_move(1'b0, 3);
    cmp("lose_perdeu", perdeu, 1);
    cmp("lose_db", db_estado, 4'hE);
    cmp("lose_rod", rodada, 2);
    cmp("lose_end", endereco, 1);
    cmp("lose_ganhou", ganhou, 0);
    cmp("lose_timeout", timeout, 0);
    cmp("lose_pronto", pronto, 1);

    // Timeout exactly TC cycles after entering espera.
    modo_timeout = 1'b1;
    drive(1'b1, 1'b0);
    wait_model(3, 10);
    repeat (TC - 1) drive(1'b0, 1'b0);
    cmp("to_before_db", db_estado, 3);
    drive(1'b0, 1'b0);
    cmp("to_db", db_estado, 4'hC);
    cmp("to_timeout", timeout, 1);
    cmp("to_pronto", pronto, 1);

    // Timeout disabled: still waiting after 40 cycles.
    modo_timeout = 1'b0;
    drive(1'b1, 1'b0);
    wait_model(3, 10);
    repeat (40) drive(1'b0, 1'b0);
    cmp("notimeout_db", db_estado, 3);

    // jogada coinciding with the last timer value loses to the timeout.
    modo_timeout = 1'b1;
    play_move(1'b1, 0);
    play_move(1'b1, 0);
    wait_model(3, 20);
    repeat (TC - 1) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    cmp("coinc_db", db_estado, 4'hC);

    // jogada one cycle earlier is taken; timer restarts after prox_jogada.
    drive(1'b1, 1'b0);
    wait_model(3, 10);
    repeat (TC - 2) drive(1'b0, 1'b0);
    igual = 1'b1;
    drive(1'b0, 1'b1);
    cmp("t6_db", db_estado, 4);
    wait_model(3, 20);
    repeat (TC - 2) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    cmp("t6b_db", db_estado, 4);
    wait_model(3, 20);
    repeat (TC - 1) drive(1'b0, 1'b0);
    cmp("restart_timer_db", db_estado, 3);
    cmp("restart_timer_end", endereco, 1);
    drive(1'b0, 1'b0);
    cmp("restart_timer_to", db_estado, 4'hC);

    // Asynchronous reset in the middle of round 2.
    modo_timeout = 1'b0;
    drive(1'b1, 1'b0);
    play_move(1'b1, 0);
    play_move(1'b1, 1);
    play_move(1'b1, 0);
    play_move(1'b1, 1);
    wait_model(3, 20);
    #2 reset = 1'b0;
    #1 check_reset_values("async");
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 1'b0);
    cmp("after_rst_db", db_estado, 0);

    // Randomized play, checked every cycle by the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) modo_timeout = ~modo_timeout;
      iniciar = ($urandom_range(0, 15) == 0);
      jogada  = ($urandom_range(0, 3) == 0);
      igual   = ($urandom_range(0, 15) != 0);
      @(negedge clock);
    end
    iniciar = 1'b0;
    jogada  = 1'b0;
    @(negedge clock);

    run_check = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
